// File: rtl/pc_gen.sv
// Fetch PC generator: owns the fetch PC, issues bus requests, tracks in-flight fetches and drops killed responses.
// Define PCGEN_PERF_EN to add saturating redirect/kill performance counters.
module pc_gen #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(64'h8000_0000),
    parameter int              INST_BYTES = 4,
    parameter int              NREDIR     = 3,
    parameter int              MAX_OUTST  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [NREDIR-1:0]          redir_valid,
    input  logic [NREDIR*XLEN-1:0]     redir_target,
    output logic                       ireq_valid,
    output logic [XLEN-1:0]            ireq_addr,
    input  logic                       ireq_ready,
    input  logic                       iresp_valid,
    input  logic [31:0]                iresp_data,
    output logic                       inst_valid,
    output logic [XLEN-1:0]            inst_pc,
    output logic [31:0]                inst_data,
`ifdef PCGEN_PERF_EN
    output logic [$clog2(MAX_OUTST):0] outst_cnt,
    output logic [31:0]                perf_redir_cnt,
    output logic [31:0]                perf_kill_cnt
`else
    output logic [$clog2(MAX_OUTST):0] outst_cnt
`endif
);

    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;
    localparam int IW = (NREDIR > 1) ? $clog2(NREDIR) : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

    logic [XLEN-1:0]      r_pc;
    logic                 r_req_vld;
    logic [XLEN-1:0]      r_fifo_pc [MAX_OUTST];
    logic [MAX_OUTST-1:0] r_fifo_kill;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_cnt;
    logic                 r_pend_vld;
    logic [XLEN-1:0]      r_pend_tgt;
    logic [IW-1:0]        r_pend_idx;

    logic                 w_r;
    logic [IW-1:0]        w_sel_idx;
    logic [XLEN-1:0]      w_sel_tgt;
    logic                 w_take;
    logic                 w_eff_vld;
    logic [XLEN-1:0]      w_eff_tgt;
    logic                 w_fire;
    logic                 w_pop;
    logic                 w_head_kill;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_req_nxt;
    logic [XLEN-1:0]      w_pc_nxt;

    // Lowest-index asserted channel wins; scanning downward lets it overwrite the others.
    always_comb begin
        w_sel_idx = '0;
        w_sel_tgt = '0;
        for (int i = NREDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                w_sel_idx = IW'(i);
                w_sel_tgt = redir_target[i*XLEN +: XLEN] & ALIGN_MASK;
            end
        end
    end

    assign w_r         = |redir_valid;
    assign w_fire      = r_req_vld & ireq_ready;
    assign w_pop       = iresp_valid & (r_cnt != '0);
    assign w_head_kill = r_fifo_kill[r_rptr];

    // A new redirect displaces the pending one only when it is at least as urgent.
    assign w_take    = w_r & (~r_pend_vld | (w_sel_idx <= r_pend_idx));
    assign w_eff_vld = w_take | r_pend_vld;
    assign w_eff_tgt = w_take ? w_sel_tgt : r_pend_tgt;

    assign w_cnt_nxt = r_cnt + CW'(w_fire) - CW'(w_pop);
    assign w_req_nxt = (r_req_vld & ~w_fire) | (~stall & (w_cnt_nxt < CW'(MAX_OUTST)));

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_fire) begin
            w_pc_nxt = w_eff_vld ? w_eff_tgt : r_pc + XLEN'(INST_BYTES);
        end else if (!r_req_vld && w_r) begin
            w_pc_nxt = w_sel_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_req_vld  <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_req_vld <= w_req_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_fire) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_fire)
                r_pend_vld <= 1'b0;
            else if (r_req_vld && w_take)
                r_pend_vld <= 1'b1;
        end
    end

    // Payload storage: only meaningful while the matching control state says valid.
    always_ff @(posedge clk) begin
        if (r_req_vld && !w_fire && w_take) begin
            r_pend_tgt <= w_sel_tgt;
            r_pend_idx <= w_sel_idx;
        end
        if (w_r) r_fifo_kill <= '1;
        if (w_fire) begin
            r_fifo_pc[r_wptr]   <= r_pc;
            r_fifo_kill[r_wptr] <= w_eff_vld;
        end
    end

    assign ireq_valid = r_req_vld;
    assign ireq_addr  = r_pc;
    assign inst_valid = w_pop & ~w_head_kill & ~w_r;
    assign inst_pc    = r_fifo_pc[r_rptr];
    assign inst_data  = iresp_data;
    assign outst_cnt  = r_cnt;

`ifdef PCGEN_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_redir_cnt <= '0;
            perf_kill_cnt  <= '0;
        end else begin
            perf_redir_cnt <= sat_inc(perf_redir_cnt, w_r);
            perf_kill_cnt  <= sat_inc(perf_kill_cnt, w_pop & (w_head_kill | w_r));
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pc_gen;

    localparam int          NR   = 3;
    localparam logic [63:0] RPC  = 64'h8000_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic [NR-1:0]   redir_valid;
    logic [NR*64-1:0] redir_target;
    logic            ireq_valid;
    logic [63:0]     ireq_addr;
    logic            ireq_ready;
    logic            iresp_valid;
    logic [31:0]     iresp_data;
    logic            inst_valid;
    logic [63:0]     inst_pc;
    logic [31:0]     inst_data;
    logic [2:0]      outst_cnt;
`ifdef PCGEN_PERF_EN
    logic [31:0]     perf_redir_cnt;
    logic [31:0]     perf_kill_cnt;
`endif

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
`ifdef PCGEN_PERF_EN
        .outst_cnt(outst_cnt),
        .perf_redir_cnt(perf_redir_cnt),
        .perf_kill_cnt(perf_kill_cnt)
`else
        .outst_cnt(outst_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: fetch PC, request flag, in-order queue of (pc, killed), pending redirect.
    bit          m_known = 0;
    logic [63:0] m_pc;
    bit          m_vld;
    logic [63:0] m_qpc[$];
    bit          m_qk[$];
    bit          m_pend_vld;
    logic [63:0] m_pend_tgt;
    int          m_pend_idx;
    logic [31:0] m_predir;
    logic [31:0] m_pkill;

    function automatic logic [NR*64-1:0] mk_rt(input logic [63:0] t0, input logic [63:0] t1, input logic [63:0] t2);
        return {t2, t1, t0};
    endfunction

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic step(input bit rst_n, input bit st, input logic [NR-1:0] rv,
                        input logic [NR*64-1:0] rt, input bit rdy, input bit iv, input logic [31:0] d);
        bit          r, fire, pop, pk, take, eff_v;
        int          idx;
        logic [63:0] t, eff_t;
        @(negedge clk);
        reset = rst_n; stall = st; redir_valid = rv; redir_target = rt;
        ireq_ready = rdy; iresp_valid = iv; iresp_data = d;
        #1;
        r = (rv != 0);
        idx = 0;
        t = 0;
        for (int i = 0; i < NR; i++) begin
            if (rv[i]) begin
                idx = i;
                t = rt[i*64 +: 64] & ~64'h3;
                break;
            end
        end
        pop = iv && (m_qpc.size() > 0);
        pk  = pop ? m_qk[0] : 1'b0;
        if (m_known) begin
            chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, m_vld});
            chk("ireq_addr", ireq_addr, m_pc);
            chk("outst_cnt", {61'd0, outst_cnt}, 64'(m_qpc.size()));
            chk("inst_valid", {63'd0, inst_valid}, {63'd0, pop && !pk && !r});
            if (pop && !pk && !r) begin
                chk("inst_pc", inst_pc, m_qpc[0]);
                chk("inst_data", {32'd0, inst_data}, {32'd0, d});
            end
`ifdef PCGEN_PERF_EN
            chk("perf_redir", {32'd0, perf_redir_cnt}, {32'd0, m_predir});
            chk("perf_kill", {32'd0, perf_kill_cnt}, {32'd0, m_pkill});
`endif
        end
        if (!rst_n) begin
            m_known = 1; m_pc = RPC; m_vld = 0; m_pend_vld = 0;
            m_qpc.delete(); m_qk.delete(); m_predir = 0; m_pkill = 0;
            return;
        end
        if (r) m_predir = sat1(m_predir);
        if (pop && (pk || r)) m_pkill = sat1(m_pkill);
        fire = m_vld && rdy;
        if (pop) begin
            void'(m_qpc.pop_front());
            void'(m_qk.pop_front());
        end
        if (r) foreach (m_qk[i]) m_qk[i] = 1;
        take = r && (!m_pend_vld || idx <= m_pend_idx);
        if (fire) begin
            eff_v = take || m_pend_vld;
            eff_t = take ? t : m_pend_tgt;
            m_qpc.push_back(m_pc);
            m_qk.push_back(eff_v);
            m_pc = eff_v ? eff_t : m_pc + 64'd4;
            m_pend_vld = 0;
        end else if (!m_vld) begin
            if (r) m_pc = t;
        end else if (take) begin
            m_pend_vld = 1; m_pend_tgt = t; m_pend_idx = idx;
        end
        m_vld = (m_vld && !fire) || (!st && m_qpc.size() < 4);
    endtask

    task automatic do_reset();
        step(0, 0, '0, '0, 0, 0, 0);
        step(0, 0, '0, '0, 0, 1, 0);
    endtask

    logic [NR-1:0]    rv;
    logic [NR*64-1:0] rt;

    initial begin
        reset = 0; stall = 0; redir_valid = '0; redir_target = '0;
        ireq_ready = 0; iresp_valid = 0; iresp_data = '0;

        // Sequential fetch, fill to capacity, one response frees one slot
        do_reset();
        step(1, 0, '0, '0, 1, 0, 0);
        chk("rst_vld", {63'd0, ireq_valid}, 64'd0);
        chk("rst_addr", ireq_addr, RPC);
        chk("rst_cnt", {61'd0, outst_cnt}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, '0, '0, 1, 0, 0);
            chk("seq_addr", ireq_addr, RPC + 64'(4 * i));
        end
        step(1, 0, '0, '0, 1, 0, 0);
        chk("full_vld", {63'd0, ireq_valid}, 64'd0);
        chk("full_cnt", {61'd0, outst_cnt}, 64'd4);
        step(1, 0, '0, '0, 1, 1, 32'h1111_0001);
        chk("resp0_pc", inst_pc, RPC);
        step(1, 0, '0, '0, 1, 0, 0);
        chk("refire_addr", ireq_addr, RPC + 64'h10);
        step(1, 0, '0, '0, 1, 0, 0);
        chk("refull_vld", {63'd0, ireq_valid}, 64'd0);
        for (int i = 0; i < 4; i++) step(1, 1, '0, '0, 1, 1, $urandom);
        step(1, 1, '0, '0, 1, 1, 32'hDEAD_BEEF);
        chk("stray_iv", {63'd0, inst_valid}, 64'd0);
        chk("stray_cnt", {61'd0, outst_cnt}, 64'd0);
        for (int i = 0; i < 3; i++) step(1, 1, '0, '0, 1, 0, 0);
        chk("stall_vld", {63'd0, ireq_valid}, 64'd0);

        // Held request with a redirect arriving mid-hold
        do_reset();
        step(1, 0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            rv = (i == 1) ? 3'b010 : 3'b000;
            step(1, 0, rv, mk_rt(64'd0, 64'h8000_0102, 64'd0), 0, 0, 0);
            chk("hold_addr", ireq_addr, RPC);
            chk("hold_cnt", {61'd0, outst_cnt}, 64'd0);
        end
        step(1, 1, '0, '0, 1, 0, 0);
        step(1, 1, '0, '0, 1, 0, 0);
        chk("redir_cnt", {61'd0, outst_cnt}, 64'd1);
        chk("redir_addr", ireq_addr, 64'h8000_0100);
        step(1, 1, '0, '0, 1, 1, 32'h2222_0002);
        chk("killed_iv", {63'd0, inst_valid}, 64'd0);

        // Simultaneous ch0/ch2 redirect with three fetches outstanding
        do_reset();
        step(1, 0, '0, '0, 1, 0, 0);
        step(1, 0, '0, '0, 1, 0, 0);
        step(1, 0, '0, '0, 1, 0, 0);
        step(1, 1, '0, '0, 1, 0, 0);
        step(1, 1, 3'b101, mk_rt(64'h9000_0000, 64'd0, 64'hA000_0000), 1, 0, 0);
        chk("multi_cnt", {61'd0, outst_cnt}, 64'd3);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, '0, '0, 1, 1, $urandom);
            chk("multi_drop", {63'd0, inst_valid}, 64'd0);
        end
        step(1, 0, '0, '0, 1, 0, 0);
        step(1, 1, '0, '0, 1, 0, 0);
        chk("multi_addr", ireq_addr, 64'h9000_0000);
        step(1, 1, '0, '0, 1, 1, 32'h3333_0003);
        chk("multi_iv", {63'd0, inst_valid}, 64'd1);
        chk("multi_pc", inst_pc, 64'h9000_0000);

        // Randomized traffic, including targets near the top of the address space
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NR; i++) begin
                rv[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 3) == 0)
                    rt[i*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                else
                    rt[i*64 +: 64] = {$urandom, $urandom};
            end
            step($urandom_range(0, 499) != 0, $urandom_range(0, 3) == 0, rv, rt,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
